acceso_mem: RTL and testbench

Memory-stage access controller for the segmented processor. It consumes the `LeerMem`/`EscrMem` control bits and the address/data that the EX/MEM pipeline register delivers. It runs a request/acknowledge handshake with the data memory and stalls the pipeline until the access completes or times out. Read data is returned to the MEM/WB path together with a one-cycle valid strobe.

---
 rtl/acceso_mem_if.sv | 38 +++
 rtl/acceso_mem.sv | 126 ++++++++++++
 tb/tb_acceso_mem.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/acceso_mem_if.sv
// Bus between the MEM-stage access controller, the pipeline and data memory.
// master = controller side, slave = pipeline/memory environment side.
interface acceso_mem_if #(
    parameter int ANCHO_DATO = 32,
    parameter int ANCHO_DIR  = 32
);
    logic                  LeerMem;
    logic                  EscrMem;
    logic [ANCHO_DIR-1:0]  Direccion;
    logic [ANCHO_DATO-1:0] DatoEscr;
    logic                  MemAck;
    logic [ANCHO_DATO-1:0] MemDatoLeido;
    logic                  MemReq;
    logic                  MemEscr;
    logic [ANCHO_DIR-1:0]  MemDir;
    logic [ANCHO_DATO-1:0] MemDato;
    logic [ANCHO_DATO-1:0] DatoLeido;
    logic                  DatoValido;
    logic                  Parada;
    logic                  ErrorTiempo;
    logic                  ErrorCtrl;

    modport master (
        input  LeerMem, EscrMem, Direccion, DatoEscr,
        input  MemAck, MemDatoLeido,
        output MemReq, MemEscr, MemDir, MemDato,
        output DatoLeido, DatoValido, Parada,
        output ErrorTiempo, ErrorCtrl
    );

    modport slave (
        output LeerMem, EscrMem, Direccion, DatoEscr,
        output MemAck, MemDatoLeido,
        input  MemReq, MemEscr, MemDir, MemDato,
        input  DatoLeido, DatoValido, Parada,
        input  ErrorTiempo, ErrorCtrl
    );
endinterface

// File: rtl/acceso_mem.sv
// MEM-stage data memory access controller: req/ack handshake with
// timeout, pipeline stall and one-cycle read-valid strobe.
module acceso_mem #(
    parameter int ANCHO_DATO = 32,
    parameter int ANCHO_DIR  = 32,
    parameter int MAX_ESPERA = 15,
    parameter int ANCHO_CONT = 4
) (
    input logic          clk,
    input logic          reset,
    acceso_mem_if.master bus
);
    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        ESPERA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam logic [ANCHO_CONT-1:0] CONT_FIN =
        ANCHO_CONT'(MAX_ESPERA - 1);

    estado_t               estado_q, estado_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_escr_q, mem_escr_d;
    logic [ANCHO_DIR-1:0]  mem_dir_q, mem_dir_d;
    logic [ANCHO_DATO-1:0] mem_dato_q, mem_dato_d;
    logic [ANCHO_DATO-1:0] dato_leido_q, dato_leido_d;
    logic                  error_tiempo_q, error_tiempo_d;
    logic                  error_ctrl_q, error_ctrl_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;

    logic pide;
    logic vence;

    assign pide  = bus.LeerMem | bus.EscrMem;
    assign vence = (cont_q == CONT_FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q       <= REPOSO;
            mem_req_q      <= 1'b0;
            mem_escr_q     <= 1'b0;
            mem_dir_q      <= '0;
            mem_dato_q     <= '0;
            dato_leido_q   <= '0;
            error_tiempo_q <= 1'b0;
            error_ctrl_q   <= 1'b0;
            cont_q         <= '0;
        end else begin
            estado_q       <= estado_d;
            mem_req_q      <= mem_req_d;
            mem_escr_q     <= mem_escr_d;
            mem_dir_q      <= mem_dir_d;
            mem_dato_q     <= mem_dato_d;
            dato_leido_q   <= dato_leido_d;
            error_tiempo_q <= error_tiempo_d;
            error_ctrl_q   <= error_ctrl_d;
            cont_q         <= cont_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            REPOSO: if (pide) estado_d = ESPERA;
            ESPERA: if (bus.MemAck || vence) estado_d = FIN;
            FIN:    estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    always_comb begin
        mem_req_d      = mem_req_q;
        mem_escr_d     = mem_escr_q;
        mem_dir_d      = mem_dir_q;
        mem_dato_d     = mem_dato_q;
        dato_leido_d   = dato_leido_q;
        error_tiempo_d = error_tiempo_q;
        error_ctrl_d   = 1'b0;
        cont_d         = cont_q;
        unique case (estado_q)
            REPOSO: begin
                if (pide) begin
                    mem_dir_d    = bus.Direccion;
                    mem_dato_d   = bus.DatoEscr;
                    // A conflicting request is resolved as a write
                    mem_escr_d   = bus.EscrMem;
                    mem_req_d    = 1'b1;
                    cont_d       = '0;
                    error_ctrl_d = bus.LeerMem & bus.EscrMem;
                end
            end
            ESPERA: begin
                cont_d = cont_q + ANCHO_CONT'(1);
                if (bus.MemAck) begin
                    if (!mem_escr_q) dato_leido_d = bus.MemDatoLeido;
                    mem_req_d = 1'b0;
                end else if (vence) begin
                    error_tiempo_d = 1'b1;
                    if (!mem_escr_q) dato_leido_d = '0;
                    mem_req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.Parada     = 1'b0;
        bus.DatoValido = 1'b0;
        unique case (estado_q)
            REPOSO: bus.Parada = pide;
            ESPERA: bus.Parada = 1'b1;
            FIN:    bus.DatoValido = 1'b1;
            default: ;
        endcase
    end

    assign bus.MemReq      = mem_req_q;
    assign bus.MemEscr     = mem_escr_q;
    assign bus.MemDir      = mem_dir_q;
    assign bus.MemDato     = mem_dato_q;
    assign bus.DatoLeido   = dato_leido_q;
    assign bus.ErrorTiempo = error_tiempo_q;
    assign bus.ErrorCtrl   = error_ctrl_q;
endmodule

// File: tb/tb_acceso_mem.sv
// Bench for acceso_mem: per-cycle vector table plus hand sequences
// for timeout and mid-access reset.
module tb_acceso_mem;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    acceso_mem_if #(.ANCHO_DATO(32), .ANCHO_DIR(32)) bus ();

    acceso_mem #(
        .ANCHO_DATO(32),
        .ANCHO_DIR (32),
        .MAX_ESPERA(15),
        .ANCHO_CONT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [101:0] sal_t;

    typedef struct {
        logic        l;
        logic        e;
        logic [31:0] dir;
        logic [31:0] dato;
        logic        ack;
        logic [31:0] rd;
        sal_t        exp;
    } vec_t;

    vec_t tbl[22];

    // Output order: Parada, MemReq, MemEscr, MemDir, MemDato,
    // DatoLeido, DatoValido, ErrorTiempo, ErrorCtrl
    function automatic sal_t mk(
        input logic p, input logic rq, input logic es,
        input logic [31:0] md, input logic [31:0] mdt,
        input logic [31:0] dl, input logic v,
        input logic et, input logic ec);
        return {p, rq, es, md, mdt, dl, v, et, ec};
    endfunction

    function automatic vec_t row(
        input logic l, input logic e,
        input logic [31:0] dir, input logic [31:0] dato,
        input logic ack, input logic [31:0] rd, input sal_t exp);
        vec_t r;
        r.l = l; r.e = e; r.dir = dir; r.dato = dato;
        r.ack = ack; r.rd = rd; r.exp = exp;
        return r;
    endfunction

    function automatic sal_t actual();
        return {bus.Parada, bus.MemReq, bus.MemEscr, bus.MemDir,
                bus.MemDato, bus.DatoLeido, bus.DatoValido,
                bus.ErrorTiempo, bus.ErrorCtrl};
    endfunction

    task automatic chk(input string nm, input sal_t act, input sal_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic l, input logic e,
                         input logic [31:0] dir, input logic [31:0] dato,
                         input logic ack, input logic [31:0] rd);
        bus.LeerMem      = l;
        bus.EscrMem      = e;
        bus.Direccion    = dir;
        bus.DatoEscr     = dato;
        bus.MemAck       = ack;
        bus.MemDatoLeido = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;

    initial begin
        total = 0;
        bad   = 0;

        tbl[0]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 0, 32'h0,   32'h0,    32'h0, 0, 0, 0));
        // read, immediate ack
        tbl[1]  = row(1, 0, 32'h40,  32'h0,    0, 32'h0,
                      mk(1, 0, 0, 32'h0,   32'h0,    32'h0, 0, 0, 0));
        tbl[2]  = row(0, 0, 32'h0,   32'h0,    1, DB,
                      mk(1, 1, 0, 32'h40,  32'h0,    32'h0, 0, 0, 0));
        tbl[3]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 0, 32'h40,  32'h0,    DB,    1, 0, 0));
        tbl[4]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 0, 32'h40,  32'h0,    DB,    0, 0, 0));
        // write, ack in cycle 3
        tbl[5]  = row(0, 1, 32'h80,  32'h1234, 0, 32'h0,
                      mk(1, 0, 0, 32'h40,  32'h0,    DB,    0, 0, 0));
        tbl[6]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(1, 1, 1, 32'h80,  32'h1234, DB,    0, 0, 0));
        tbl[7]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(1, 1, 1, 32'h80,  32'h1234, DB,    0, 0, 0));
        tbl[8]  = row(0, 0, 32'h0,   32'h0,    1, 32'h55555555,
                      mk(1, 1, 1, 32'h80,  32'h1234, DB,    0, 0, 0));
        tbl[9]  = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 1, 32'h80,  32'h1234, DB,    1, 0, 0));
        // both request bits: write plus ErrorCtrl pulse
        tbl[10] = row(1, 1, 32'hC0,  32'hAAAA, 0, 32'h0,
                      mk(1, 0, 1, 32'h80,  32'h1234, DB,    0, 0, 0));
        tbl[11] = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(1, 1, 1, 32'hC0,  32'hAAAA, DB,    0, 0, 1));
        tbl[12] = row(0, 0, 32'h0,   32'h0,    1, 32'h12,
                      mk(1, 1, 1, 32'hC0,  32'hAAAA, DB,    0, 0, 0));
        tbl[13] = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 1, 32'hC0,  32'hAAAA, DB,    1, 0, 0));
        // back-to-back, inputs held through FIN
        tbl[14] = row(1, 0, 32'h100, 32'h22,   0, 32'h0,
                      mk(1, 0, 1, 32'hC0,  32'hAAAA, DB,    0, 0, 0));
        tbl[15] = row(1, 0, 32'h100, 32'h22,   1, 32'h11111111,
                      mk(1, 1, 0, 32'h100, 32'h22,   DB,    0, 0, 0));
        tbl[16] = row(1, 0, 32'h200, 32'h33,   1, 32'h99,
                      mk(0, 0, 0, 32'h100, 32'h22,   32'h11111111, 1, 0, 0));
        tbl[17] = row(1, 0, 32'h200, 32'h33,   1, 32'h99,
                      mk(1, 0, 0, 32'h100, 32'h22,   32'h11111111, 0, 0, 0));
        tbl[18] = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(1, 1, 0, 32'h200, 32'h33,   32'h11111111, 0, 0, 0));
        tbl[19] = row(0, 0, 32'h0,   32'h0,    1, 32'h77,
                      mk(1, 1, 0, 32'h200, 32'h33,   32'h11111111, 0, 0, 0));
        tbl[20] = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 0, 32'h200, 32'h33,   32'h77, 1, 0, 0));
        tbl[21] = row(0, 0, 32'h0,   32'h0,    0, 32'h0,
                      mk(0, 0, 0, 32'h200, 32'h33,   32'h77, 0, 0, 0));

        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #3;
        chk("reset_state", actual(),
            mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            next_cycle();
            drive(tbl[i].l, tbl[i].e, tbl[i].dir, tbl[i].dato,
                  tbl[i].ack, tbl[i].rd);
            #3;
            chk($sformatf("vec%0d", i), actual(), tbl[i].exp);
        end

        // timeout: read, never acknowledged
        next_cycle();
        drive(1, 0, 32'h300, 32'h0, 0, 32'h0);
        #3;
        chk("to_c0_parada", sal_t'(bus.Parada), sal_t'(1));
        for (int k = 1; k <= 15; k++) begin
            next_cycle();
            drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
            #3;
            chk($sformatf("to_c%0d", k),
                {bus.Parada, bus.MemReq, bus.DatoValido, bus.ErrorTiempo},
                sal_t'(4'b1100));
        end
        next_cycle();
        #3;
        chk("to_fin", actual(),
            mk(0, 0, 0, 32'h300, 32'h0, 32'h0, 1, 1, 0));
        next_cycle();
        #3;
        chk("to_sticky",
            {bus.ErrorTiempo, bus.DatoValido, bus.Parada},
            sal_t'(3'b100));

        // reset asserted during ESPERA cycle 2
        next_cycle();
        drive(1, 0, 32'h400, 32'h0, 0, 32'h0);
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #3;
        chk("rst_pre_req", sal_t'(bus.MemReq), sal_t'(1));
        next_cycle();
        reset = 1'b1;
        #1;
        chk("rst_async", actual(),
            mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0));
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(0, 0, 32'h0, 32'h0, 1, 32'h5);
            #3;
            chk($sformatf("rst_idle%0d", k),
                {bus.MemReq, bus.DatoValido, bus.Parada},
                sal_t'(3'b000));
        end
        next_cycle();
        drive(1, 0, 32'h500, 32'h0, 0, 32'h0);
        #3;
        chk("rst_new_c0", sal_t'(bus.Parada), sal_t'(1));
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 1, 32'hCAFE);
        #3;
        chk("rst_new_c1", actual(),
            mk(1, 1, 0, 32'h500, 32'h0, 32'h0, 0, 0, 0));
        next_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
        #3;
        chk("rst_new_fin", actual(),
            mk(0, 0, 0, 32'h500, 32'h0, 32'hCAFE, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
